ram16k_arbiter: RTL and testbench
=================================

// Module: ram16k_arbiter
// PURPOSE
//  Shares the single-port 16K x 16 data RAM between two requesters (m0 = CPU data port,
//  m1 = loader/DMA) using a req/ack handshake and round-robin or fixed priority.
//  Optionally zero-fills the whole RAM after reset before granting any access.
//  Sits between the requesters and the ram16k instance; sole driver of its load/addres/data_in.
// PARAMETERS
//  CLEAR_ON_RESET  1  1: walk all 16384 words writing 0 after reset; 0: skip, run immediately
//  FIXED_PRIO      0  1: m0 always wins contention; 0: round-robin between m0/m1
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   reset, asynchronous, active-low
//  m0_req     in   1   m0 request; held with m0_we/addr/wdata stable until m0_ack
//  m0_we      in   1   1 = write, 0 = read
//  m0_addr    in   14  word address
//  m0_wdata   in   16  write data
//  m0_ack     out  1   one-cycle completion pulse
//  m0_rdata   out  16  read data, valid in m0_ack cycle, held until next m0 read ack
//  m1_*       ---  --  identical set for m1 (m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata)
//  ram_load   out  1   to ram16k load
//  ram_addr   out  14  to ram16k addres
//  ram_din    out  16  to ram16k data_in
//  ram_dout   in   16  from ram16k data_out (combinational read of ram_addr)
//  init_done  out  1   1 once clearing finished (or immediately if CLEAR_ON_RESET=0)
// BEHAVIOUR
//  - Reset (rst=0): state=INIT, clear counter=0, last_gnt=m1, all outputs 0, rdata regs 0.
//    Reset mid-access aborts: ram_load drops immediately, no ack, no write commits.
//  - FSM states: INIT, IDLE, ACCESS, ACK.
//  - INIT: ram_load=1, ram_din=0, ram_addr=counter; counter++ each cycle. After addr 16383
//    is written, go to IDLE and set init_done=1 (stays 1 until reset). Requests ignored, no acks.
//    If CLEAR_ON_RESET=0: INIT lasts one cycle, no writes, init_done=1 on entering IDLE.
//  - IDLE: if any req, pick winner, latch its we/addr/wdata and id, go to ACCESS; else stay.
//    Only m0 -> m0; only m1 -> m1; both -> FIXED_PRIO ? m0 : requester != last_gnt.
//    last_gnt updated at grant. First contention after reset grants m0.
//  - ACCESS: ram_addr=latched addr, ram_din=latched wdata, ram_load=latched we (write commits on
//    the edge ending ACCESS). Read: ram_dout captured into winner's rdata reg at that edge. -> ACK.
//  - ACK: winner's ack=1 for exactly one cycle; ram_load=0. -> IDLE.
//  - Latency: req seen in IDLE at cycle t -> ack at t+2; 3 cycles per access, back-to-back
//    if requester keeps req high with new fields after ack. Requester drops req or presents
//    next op in the cycle after ack.
//  - Outside INIT/ACCESS: ram_load=0, ram_addr=0, ram_din=0. Loser's req is untouched and
//    served in a later IDLE; no request is dropped or duplicated.
//  - Never ack both masters in one cycle; never ack a master that did not request.
//  - Read of non-winner's rdata reg is unchanged by the other master's traffic.
// STRUCTURE
//  - Package ram_arb_pkg: ADDR_W=14, DATA_W=16, RAM_WORDS=16384, typedef enum state_t
//    {INIT, IDLE, ACCESS, ACK}, typedef struct cmd_t {we, addr, wdata, id}.
//  - Sub-module rr_arb2: 2-way grant pick from {req0, req1, last_gnt, fixed_prio}, combinational.
//  - Remainder (FSM, clear counter, command latch, rdata regs) in this module.
// TESTING
//  1 CLEAR_ON_RESET=1, preload RAM nonzero, release rst -> ram_load=1 for exactly 16384 cycles,
//    addrs 0..16383 in order, init_done rises next cycle; then m0 read 0x2A55 -> rdata 0x0000.
//  2 m0 write 0x1234 to 0x0100, then m1 read 0x0100 -> m0_ack at t+2, m1_rdata=0x1234, m1_ack once.
//  3 m0 and m1 both req continuously (FIXED_PRIO=0) -> grants m0,m1,m0,m1...; each ack 1 cycle,
//    never simultaneous; FIXED_PRIO=1 same stimulus -> m0 only while m0_req high.
//  4 m1 write 0xBEEF to 0x3FFF, m0 write 0x0001 to 0x0000 -> both read back correct; no wrap alias.
//  5 assert rst during ACCESS of write 0xAAAA to 0x0005 -> no ack, ram_load falls
//    asynchronously, INIT restarts at addr 0.
//  6 req during INIT -> no ack until init_done=1, then ack 2 cycles after first IDLE.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the 16K x 16 data RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned RAM_WORDS = 16384;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACCESS,
        ACK
    } state_t;

    // id: 0 = m0 (CPU data port), 1 = m1 (loader/DMA)
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              id;
    } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant pick: a lone requester always wins; on contention either m0 wins
// outright (fixed priority) or the requester that was not granted last time wins.
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_gnt,
    input  logic i_fixed_prio,
    output logic o_valid,
    output logic o_gnt
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_gnt   = 1'b0;
        unique case ({i_req1, i_req0})
            2'b01:   o_gnt = 1'b0;
            2'b10:   o_gnt = 1'b1;
            2'b11:   o_gnt = i_fixed_prio ? 1'b0 : ~i_last_gnt;
            default: o_gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram16k_arbiter.sv
// Shares the single-port 16K x 16 data RAM between the CPU data port (m0) and the
// loader/DMA (m1) with a req/ack handshake; optionally zero-fills the RAM after reset.
module ram16k_arbiter
    import ram_arb_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit FIXED_PRIO     = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_ram_load,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_init_done
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_init_done;
    logic              r_last_gnt;
    cmd_t              r_cmd;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_clr_last;
    logic              w_ram_load;

    rr_arb2 u_arb (
        .i_req0      (i_m0_req),
        .i_req1      (i_m1_req),
        .i_last_gnt  (r_last_gnt),
        .i_fixed_prio(FIXED_PRIO),
        .o_valid     (w_gnt_valid),
        .o_gnt       (w_gnt_id)
    );

    assign w_clr_last = !CLEAR_ON_RESET || (r_clr_cnt == ADDR_W'(RAM_WORDS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            INIT:    if (w_clr_last) w_state_next = IDLE;
            IDLE:    if (w_gnt_valid) w_state_next = ACCESS;
            ACCESS:  w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_cmd       <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            if (r_state == INIT) begin
                if (CLEAR_ON_RESET) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                if (w_clr_last) r_init_done <= 1'b1;
            end
            if (r_state == IDLE && w_gnt_valid) begin
                r_cmd.we    <= w_gnt_id ? i_m1_we    : i_m0_we;
                r_cmd.addr  <= w_gnt_id ? i_m1_addr  : i_m0_addr;
                r_cmd.wdata <= w_gnt_id ? i_m1_wdata : i_m0_wdata;
                r_cmd.id    <= w_gnt_id;
                r_last_gnt  <= w_gnt_id;
            end
            // Read data is sampled on the same edge that would commit a write.
            if (r_state == ACCESS && !r_cmd.we) begin
                if (r_cmd.id) r_m1_rdata <= i_ram_dout;
                else          r_m0_rdata <= i_ram_dout;
            end
        end
    end

    always_comb begin
        w_ram_load = 1'b0;
        o_ram_addr = '0;
        o_ram_din  = '0;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        unique case (r_state)
            INIT: begin
                if (CLEAR_ON_RESET) begin
                    w_ram_load = 1'b1;
                    o_ram_addr = r_clr_cnt;
                end
            end
            IDLE: ;
            ACCESS: begin
                w_ram_load = r_cmd.we;
                o_ram_addr = r_cmd.addr;
                o_ram_din  = r_cmd.wdata;
            end
            ACK: begin
                o_m0_ack = !r_cmd.id;
                o_m1_ack = r_cmd.id;
            end
            default: ;
        endcase
    end

    // Reset parks the FSM in INIT, which would otherwise start a clear write while rst is low.
    assign o_ram_load  = w_ram_load & i_rst_n;
    assign o_init_done = r_init_done;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Scoreboard bench for ram16k_arbiter: RAM model, per-master expectation queues, one task per scenario.
module tb_ram16k_arbiter;
    import ram_arb_pkg::*;

    typedef struct packed {
        logic        we;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rstb_n;
    logic m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [13:0] m0_addr, m1_addr, ram_addr;
    logic [15:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, ram_din, ram_dout;
    logic ram_load, init_done;

    logic b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack, b_ram_load, b_init_done;
    logic [13:0] b_m0_addr, b_m1_addr, b_ram_addr;
    logic [15:0] b_m0_rdata, b_m1_rdata, b_ram_din, b_ram_dout;

    ram16k_arbiter #(.CLEAR_ON_RESET(1'b1), .FIXED_PRIO(1'b0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_ack(m0_ack), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_ack(m1_ack), .o_m1_rdata(m1_rdata),
        .o_ram_load(ram_load), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
        .i_ram_dout(ram_dout), .o_init_done(init_done)
    );

    ram16k_arbiter #(.CLEAR_ON_RESET(1'b0), .FIXED_PRIO(1'b1)) dut_fixed (
        .i_clk(clk), .i_rst_n(rstb_n),
        .i_m0_req(b_m0_req), .i_m0_we(b_m0_we), .i_m0_addr(b_m0_addr), .i_m0_wdata(16'h0),
        .o_m0_ack(b_m0_ack), .o_m0_rdata(b_m0_rdata),
        .i_m1_req(b_m1_req), .i_m1_we(b_m1_we), .i_m1_addr(b_m1_addr), .i_m1_wdata(16'h0),
        .o_m1_ack(b_m1_ack), .o_m1_rdata(b_m1_rdata),
        .o_ram_load(b_ram_load), .o_ram_addr(b_ram_addr), .o_ram_din(b_ram_din),
        .i_ram_dout(b_ram_dout), .o_init_done(b_init_done)
    );

    // ram16k models: synchronous write, combinational read
    logic [15:0] mem  [RAM_WORDS];
    logic [15:0] memb [RAM_WORDS];
    logic        preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < RAM_WORDS; i++) mem[i] <= 16'hFFFF - 16'(i);
        end else if (ram_load) begin
            mem[ram_addr] <= ram_din;
        end
    end
    assign ram_dout = mem[ram_addr];

    always @(posedge clk) if (b_ram_load) memb[b_ram_addr] <= b_ram_din;
    assign b_ram_dout = memb[b_ram_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        q0[$];
    exp_t        q1[$];
    int          gnt_log[$];
    logic [15:0] shadow[int];
    logic [15:0] held0, held1;
    logic        tb_last;
    logic        prev0, prev1;

    task automatic reset_model();
        q0.delete();
        q1.delete();
        shadow.delete();
        held0   = 16'h0;
        held1   = 16'h0;
        tb_last = 1'b1;
    endtask

    // Scoreboard monitor: pops one expectation per ack and checks rdata and handshake rules.
    initial begin : monitor
        exp_t e;
        prev0 = 1'b0;
        prev1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m0_ack || m1_ack) begin
                    checks++;
                    if (m0_ack && m1_ack) begin
                        errors++;
                        $display("FAIL dual_ack: m0_ack=%b m1_ack=%b, required at most one", m0_ack, m1_ack);
                    end
                    checks++;
                    if (!init_done) begin
                        errors++;
                        $display("FAIL ack_before_init: init_done=%b, required 1", init_done);
                    end
                end
                if (m0_ack) begin
                    checks++;
                    if (prev0) begin
                        errors++;
                        $display("FAIL m0_ack_width: ack high two cycles, required one");
                    end
                    checks++;
                    if (q0.size() == 0) begin
                        errors++;
                        $display("FAIL m0_unexpected_ack: ack with no request outstanding");
                    end else begin
                        e = q0.pop_front();
                        if (!e.we) begin
                            checks++;
                            if (m0_rdata !== e.rdata) begin
                                errors++;
                                $display("FAIL m0_rdata: got %h, required %h", m0_rdata, e.rdata);
                            end
                            held0 = e.rdata;
                        end
                    end
                    checks++;
                    if (m1_rdata !== held1) begin
                        errors++;
                        $display("FAIL m1_rdata_hold: got %h, required %h", m1_rdata, held1);
                    end
                    gnt_log.push_back(0);
                    tb_last = 1'b0;
                end
                if (m1_ack) begin
                    checks++;
                    if (prev1) begin
                        errors++;
                        $display("FAIL m1_ack_width: ack high two cycles, required one");
                    end
                    checks++;
                    if (q1.size() == 0) begin
                        errors++;
                        $display("FAIL m1_unexpected_ack: ack with no request outstanding");
                    end else begin
                        e = q1.pop_front();
                        if (!e.we) begin
                            checks++;
                            if (m1_rdata !== e.rdata) begin
                                errors++;
                                $display("FAIL m1_rdata: got %h, required %h", m1_rdata, e.rdata);
                            end
                            held1 = e.rdata;
                        end
                    end
                    checks++;
                    if (m0_rdata !== held0) begin
                        errors++;
                        $display("FAIL m0_rdata_hold: got %h, required %h", m0_rdata, held0);
                    end
                    gnt_log.push_back(1);
                    tb_last = 1'b1;
                end
            end
            prev0 = m0_ack;
            prev1 = m1_ack;
        end
    end

    // One handshake on master m; lat > 0 also checks ack arrives lat cycles after an idle req.
    task automatic issue(input int m, input logic we, input logic [13:0] addr,
                         input logic [15:0] wdata, input int lat);
        exp_t e;
        int   c0;
        bit   got;
        if (lat > 0) @(negedge clk);
        e.we    = we;
        e.rdata = we ? 16'h0 : (shadow.exists(int'(addr)) ? shadow[int'(addr)] : 16'h0);
        if (we) shadow[int'(addr)] = wdata;
        if (m == 0) begin
            q0.push_back(e);
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            q1.push_back(e);
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        c0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout m%0d addr %h: no ack in 40 cycles, required ack", m, addr);
        end else if (lat > 0) begin
            checks++;
            if (cyc - c0 != lat) begin
                errors++;
                $display("FAIL latency m%0d: got %0d cycles, required %0d", m, cyc - c0, lat);
            end
        end
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    // Entered right after rst_n rises; follows the clear walk until ram_load drops.
    task automatic run_init(input string tag);
        int n   = 0;
        int bad = 0;
        int nz  = 0;
        for (int i = 0; i < 20000; i++) begin
            #1;
            if (!ram_load) break;
            if (ram_addr !== 14'(n) || ram_din !== 16'h0 || init_done !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != RAM_WORDS) begin
            errors++;
            $display("FAIL %s_clear_len: got %0d load cycles, required %0d", tag, n, RAM_WORDS);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_clear_order: got %0d bad cycles, required 0", tag, bad);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_init_done: got %b, required 1", tag, init_done);
        end
        for (int i = 0; i < RAM_WORDS; i++) if (mem[i] !== 16'h0) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL %s_clear_mem: got %0d nonzero words, required 0", tag, nz);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rstb_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0;
        reset_model();
        for (int i = 0; i < RAM_WORDS; i++) memb[i] = 16'h0;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
        checks++;
        if ({ram_load, ram_addr, ram_din} !== 31'h0) begin
            errors++;
            $display("FAIL reset_ram_port: got load=%b addr=%h din=%h, required 0", ram_load, ram_addr, ram_din);
        end
        checks++;
        if ({m0_ack, m1_ack, init_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got acks=%b%b init_done=%b, required 0", m0_ack, m1_ack, init_done);
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h, required 0", m0_rdata, m1_rdata);
        end
        rstb_n = 1'b1;
        #1;
        checks++;
        if (b_ram_load !== 1'b0 || b_init_done !== 1'b0) begin
            errors++;
            $display("FAIL noclear_init: got load=%b init_done=%b, required 0 0", b_ram_load, b_init_done);
        end
        @(negedge clk);
        checks++;
        if (b_init_done !== 1'b1 || b_ram_load !== 1'b0) begin
            errors++;
            $display("FAIL noclear_idle: got init_done=%b load=%b, required 1 0", b_init_done, b_ram_load);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        rst_n = 1'b1;
        run_init("t1");
        issue(0, 1'b0, 14'h2A55, 16'h0, 2);
    endtask

    task automatic test_write_read();
        int extra = 0;
        issue(0, 1'b1, 14'h0100, 16'h1234, 2);
        issue(1, 1'b0, 14'h0100, 16'h0, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m1_ack) extra++;
        end
        checks++;
        if (extra != 0 || mem[14'h0100] !== 16'h1234) begin
            errors++;
            $display("FAIL write_read: extra m1 acks %0d mem %h, required 0 1234", extra, mem[14'h0100]);
        end
    endtask

    task automatic test_round_robin();
        int   bad = 0;
        logic first;
        @(negedge clk);
        first = ~tb_last;
        gnt_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, 1'b0, 14'h0100, 16'h0, 0);
            end
            begin
                for (int j = 0; j < 4; j++) issue(1, 1'b0, 14'h2A55, 16'h0, 0);
            end
        join
        checks++;
        if (gnt_log.size() != 8) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, required 8", gnt_log.size());
        end
        for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] != int'(first ^ i[0])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rr_order: got %0d out-of-turn grants, required 0", bad);
        end
    endtask

    task automatic test_fixed_prio();
        int a0 = 0;
        int a1 = 0;
        int dual = 0;
        int got_at = -1;
        @(negedge clk);
        b_m0_addr = 14'h0010; b_m1_addr = 14'h0020;
        b_m0_req = 1'b1; b_m1_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_m0_ack) a0++;
            if (b_m1_ack) a1++;
            if (b_m0_ack && b_m1_ack) dual++;
        end
        checks++;
        if (a0 != 10 || a1 != 0 || dual != 0) begin
            errors++;
            $display("FAIL fixed_prio: got m0=%0d m1=%0d dual=%0d, required 10 0 0", a0, a1, dual);
        end
        b_m0_req = 1'b0;
        for (int i = 0; i < 6 && got_at < 0; i++) begin
            @(negedge clk);
            if (b_m1_ack) got_at = i;
        end
        checks++;
        if (got_at != 1) begin
            errors++;
            $display("FAIL fixed_m1_served: got ack at %0d, required 1", got_at);
        end
        b_m1_req = 1'b0;
    endtask

    task automatic test_wrap();
        issue(1, 1'b1, 14'h3FFF, 16'hBEEF, 2);
        issue(0, 1'b1, 14'h0000, 16'h0001, 2);
        issue(0, 1'b0, 14'h3FFF, 16'h0, 2);
        issue(1, 1'b0, 14'h0000, 16'h0, 2);
        checks++;
        if (mem[14'h3FFF] !== 16'hBEEF || mem[14'h0000] !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_mem: got %h %h, required BEEF 0001", mem[14'h3FFF], mem[14'h0000]);
        end
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        @(negedge clk);
        @(negedge clk);
        m0_we = 1'b1; m0_addr = 14'h0005; m0_wdata = 16'hAAAA; m0_req = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (ram_load !== 1'b1 || ram_addr !== 14'h0005) begin
            errors++;
            $display("FAIL abort_access: got load=%b addr=%h, required 1 0005", ram_load, ram_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_load !== 1'b0 || ram_addr !== 14'h0) begin
            errors++;
            $display("FAIL abort_async: got load=%b addr=%h, required 0 0000", ram_load, ram_addr);
        end
        m0_req = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        checks++;
        if (acks != 0 || mem[14'h0005] !== 16'h0 || {m0_rdata, m1_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL abort_state: got acks=%0d mem=%h rdata=%h %h, required 0 0000 0 0",
                     acks, mem[14'h0005], m0_rdata, m1_rdata);
        end
        rst_n = 1'b1;
        run_init("t5");
    endtask

    task automatic test_req_during_init();
        exp_t e;
        int   early = 0;
        int   c0;
        bit   got = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        reset_model();
        e.we = 1'b0; e.rdata = 16'h0;
        q0.push_back(e);
        m0_we = 1'b0; m0_addr = 14'h0100; m0_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (m0_ack) early++;
            if (init_done) break;
        end
        checks++;
        if (init_done !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL init_block: got init_done=%b early acks=%0d, required 1 0", init_done, early);
        end
        c0 = cyc;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = m0_ack;
        end
        checks++;
        if (!got || cyc - c0 != 2) begin
            errors++;
            $display("FAIL init_first_ack: got ack=%b after %0d cycles, required 1 after 2", got, cyc - c0);
        end
        m0_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_round_robin();
        test_fixed_prio();
        test_wrap();
        test_reset_abort();
        test_req_during_init();
        repeat (4) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL outstanding: got %0d/%0d unacked requests, required 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
